// File: rtl/dmem_pkg.sv
// Shared widths, FSM state type and address-range helper for the data-memory responder.
package dmem_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth);
    return (int'(addr) < depth);
  endfunction

endpackage

// File: rtl/dmem_sat_cnt.sv
// Saturating event counter with synchronous clear; sticks at all-ones instead of wrapping.
module dmem_sat_cnt
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: self-clears after reset, then serves single-port core accesses
// plus a backdoor port. Define DMEM_STATS_EN to add rd_cnt/wr_cnt access counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int RD_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] Data2Mem,
  output logic [DATA_W-1:0] ReadDataMem,
  output logic              ready,
  output logic              proto_err,
  output logic              addr_err,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata
`ifdef DMEM_STATS_EN
  ,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
`endif
);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [ADDR_W-1:0] clr_ptr_d;
  logic              proto_err_q;
  logic              proto_err_d;
  logic              addr_err_q;
  logic              addr_err_d;

  // Sized to the full address space so any 7-bit index is legal; only DEPTH words are used.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic              clr_wr;
  logic              a_ok;
  logic              dbg_ok;
  logic              access;
  logic              proto_hit;
  logic              core_wr;
  logic              core_rd;
  logic              wr_acc;
  logic              dbg_wr;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_wr    = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_wr    = !rst;
      clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
        state_d = ST_READY;
      end
    end
  end

  always_comb begin
    a_ok        = addr_in_range(A, DEPTH);
    dbg_ok      = addr_in_range(dbg_addr, DEPTH);
    access      = (state_q == ST_READY) && !CEN && (!WEN || !OEN);
    proto_hit   = access && !WEN && !OEN;
    core_wr     = access && !WEN && a_ok;
    core_rd     = access && WEN && !OEN && a_ok;
    wr_acc      = core_wr && !proto_hit;
    // The core port wins when both ports target the same word in one cycle.
    dbg_wr      = (state_q == ST_READY) && dbg_we && dbg_ok && !(core_wr && (dbg_addr == A));
    rd_word     = core_rd ? mem_q[A] : '0;
    proto_err_d = proto_err_q | proto_hit;
    addr_err_d  = addr_err_q | (access && !a_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      proto_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      proto_err_q <= proto_err_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Array contents are never reset directly; the clear sequence zeroes them instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_wr) begin
        mem_q[clr_ptr_q] <= '0;
      end
      if (core_wr) begin
        mem_q[A] <= Data2Mem;
      end
      if (dbg_wr) begin
        mem_q[dbg_addr] <= dbg_wdata;
      end
    end
  end

  if (RD_LAT == 0) begin : g_comb_rd
    assign ReadDataMem = rd_word;
  end else begin : g_reg_rd
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (access && !OEN) begin
        rdata_d = rd_word;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign ReadDataMem = rdata_q;
  end

  assign dbg_rdata = dbg_ok ? mem_q[dbg_addr] : '0;
  assign ready     = (state_q == ST_READY);
  assign proto_err = proto_err_q;
  assign addr_err  = addr_err_q;

`ifdef DMEM_STATS_EN
  dmem_sat_cnt u_rd_cnt (
    .clk (clk),
    .clr (rst),
    .inc (core_rd),
    .cnt (rd_cnt)
  );

  dmem_sat_cnt u_wr_cnt (
    .clk (clk),
    .clr (rst),
    .inc (wr_acc),
    .cnt (wr_cnt)
  );
`endif

endmodule
